// File: rtl/miner_pkg.sv
// Shared widths, FSM encoding and status bundle for the nonce sweep front-end.
package miner_pkg;

  localparam int MSG_W     = 512;
  localparam int HASH_W    = 256;
  localparam int NONCE_W   = 32;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = MSG_W / WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CHECK,
    DONE
  } sweep_state_t;

  // Terminal status of a sweep; exactly one bit is set once a sweep completes.
  typedef struct packed {
    logic found;
    logic exhausted;
    logic timeout;
    logic aborted;
  } sweep_status_t;

endpackage

// File: rtl/hash_lt_target.sv
// Full-width unsigned digest < target compare; bit 255 is the MSB, no byte swapping.
module hash_lt_target
  import miner_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic              lt
);

  // A target of zero can never be beaten, which falls out of the unsigned compare.
  assign lt = (hash < target);

endmodule

// File: rtl/nonce_sweep_controller.sv
// Sweeps a nonce range through an external SHA core, stopping on the first
// digest below target, range exhaustion, an honoured stop, or a hash timeout.
module nonce_sweep_controller
  import miner_pkg::*;
#(
  parameter int NONCE_WORD     = 3,
  parameter int TIMEOUT_CYCLES = 127
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                stop,
  input  logic [MSG_W-1:0]    msg_template,
  input  logic [HASH_W-1:0]   target,
  input  logic [NONCE_W-1:0]  nonce_start,
  input  logic [NONCE_W-1:0]  nonce_end,
  output logic [MSG_W-1:0]    sha_msg,
  output logic                sha_begin,
  output logic                sha_enable,
  input  logic                sha_complete,
  input  logic [HASH_W-1:0]   sha_hash,
  output logic                busy,
  output logic                found,
  output logic                exhausted,
  output logic                timeout,
  output logic                aborted,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [HASH_W-1:0]   found_hash,
  output logic [NONCE_W-1:0]  hashes_done
);

  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  sweep_state_t        state, state_nxt;
  sweep_status_t       status_q;
  logic [MSG_W-1:0]    tmpl_q;
  logic [HASH_W-1:0]   target_q;
  logic [HASH_W-1:0]   hash_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [NONCE_W-1:0]  end_q;
  logic [TMR_W-1:0]    timer;
  logic                stop_req;
  logic                lt_now;
  logic                lt_q;
  logic                wait_hit;
  logic                wait_expire;
  logic                last_nonce;

  assign found     = status_q.found;
  assign exhausted = status_q.exhausted;
  assign timeout   = status_q.timeout;
  assign aborted   = status_q.aborted;

  // The core keeps complete high from the previous hash for a cycle after
  // begin, so the first WAIT cycle (timer==0) never accepts it. WAIT lasts at
  // most TIMEOUT_CYCLES cycles; the last one still accepts a completion.
  assign wait_hit    = (state == WAIT) && (timer != '0) && sha_complete;
  assign wait_expire = (state == WAIT) && !wait_hit && (timer == TMR_LAST);
  assign last_nonce  = (nonce_q == end_q);

  hash_lt_target u_cmp (
    .hash   (sha_hash),
    .target (target_q),
    .lt     (lt_now)
  );

  // Nonce insertion: word 0 is the top 32 bits of the block.
  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
    localparam int HI = MSG_W - 1 - WORD_W * w;
    if (w == NONCE_WORD) begin : g_nonce
      assign sha_msg[HI -: WORD_W] = nonce_q;
    end else begin : g_tmpl
      assign sha_msg[HI -: WORD_W] = tmpl_q[HI -: WORD_W];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and SHA handshake strobes.
  always_comb begin
    state_nxt  = state;
    sha_begin  = 1'b0;
    sha_enable = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD: begin
        sha_begin  = 1'b1;
        sha_enable = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        sha_enable = 1'b1;
        if (wait_hit)         state_nxt = CHECK;
        else if (wait_expire) state_nxt = DONE;
      end
      CHECK: begin
        if (lt_q || stop_req || last_nonce) state_nxt = DONE;
        else                                state_nxt = LOAD;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep datapath: latched job, nonce walk, timer, digest capture, status.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      status_q    <= '0;
      tmpl_q      <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      nonce_q     <= '0;
      end_q       <= '0;
      timer       <= '0;
      stop_req    <= 1'b0;
      lt_q        <= 1'b0;
      busy        <= 1'b0;
      found_nonce <= '0;
      found_hash  <= '0;
      hashes_done <= '0;
    end else begin
      // Stop is remembered and only acted on between hashes.
      if (busy && stop) stop_req <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            tmpl_q      <= msg_template;
            target_q    <= target;
            end_q       <= nonce_end;
            nonce_q     <= nonce_start;
            status_q    <= '0;
            hashes_done <= '0;
            stop_req    <= 1'b0;
            busy        <= 1'b1;
          end
        end
        LOAD: timer <= '0;
        WAIT: begin
          if (wait_hit) begin
            hash_q <= sha_hash;
            lt_q   <= lt_now;
          end else begin
            timer <= timer + TMR_W'(1);
            if (wait_expire) status_q.timeout <= 1'b1;
          end
        end
        CHECK: begin
          hashes_done <= hashes_done + NONCE_W'(1);
          if (lt_q) begin
            status_q.found <= 1'b1;
            found_nonce    <= nonce_q;
            found_hash     <= hash_q;
          end else if (stop_req) begin
            status_q.aborted <= 1'b1;
          end else if (last_nonce) begin
            status_q.exhausted <= 1'b1;
          end else begin
            nonce_q <= nonce_q + NONCE_W'(1);
          end
        end
        DONE: begin
          busy     <= 1'b0;
          stop_req <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sweep_controller.sv
// Scoreboard bench for nonce_sweep_controller with a behavioural SHA stub.
module tb_nonce_sweep_controller;

  localparam int NW = 3;

  typedef struct {
    bit          found;
    bit          exhausted;
    bit          tmo;
    bit          aborted;
    logic [31:0] fnonce;
    logic [255:0] fhash;
    logic [31:0] done_cnt;
    int          begins;
    int          cmp_to_idle;
    int          en_cycles;
  } exp_t;

  logic          clk;
  logic          n_rst;
  logic          start;
  logic          stop;
  logic [511:0]  msg_template;
  logic [255:0]  target;
  logic [31:0]   nonce_start;
  logic [31:0]   nonce_end;
  logic [511:0]  sha_msg;
  logic          sha_begin;
  logic          sha_enable;
  logic          sha_complete = 1'b0;
  logic [255:0]  sha_hash = '0;
  logic          busy;
  logic          found;
  logic          exhausted;
  logic          timeout;
  logic          aborted;
  logic [31:0]   found_nonce;
  logic [255:0]  found_hash;
  logic [31:0]   hashes_done;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  bit          hang = 1'b0;
  bit          hit_en = 1'b0;
  logic [31:0] hit_nonce = '0;
  bit          begin_d = 1'b0;
  bit          s_busy = 1'b0;
  int          s_cnt = 0;

  nonce_sweep_controller #(.NONCE_WORD(NW), .TIMEOUT_CYCLES(127)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .start        (start),
    .stop         (stop),
    .msg_template (msg_template),
    .target       (target),
    .nonce_start  (nonce_start),
    .nonce_end    (nonce_end),
    .sha_msg      (sha_msg),
    .sha_begin    (sha_begin),
    .sha_enable   (sha_enable),
    .sha_complete (sha_complete),
    .sha_hash     (sha_hash),
    .busy         (busy),
    .found        (found),
    .exhausted    (exhausted),
    .timeout      (timeout),
    .aborted      (aborted),
    .found_nonce  (found_nonce),
    .found_hash   (found_hash),
    .hashes_done  (hashes_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stub digest: a programmed hit nonce gives a tiny hash, others a huge one.
  function automatic logic [255:0] stub_f(input logic [511:0] m);
    logic [31:0] n;
    n = m[511-32*NW -: 32];
    if (hit_en && n == hit_nonce) return {224'd0, n};
    return {n, {224{1'b1}}};
  endfunction

  // SHA stub: completes 64 cycles after begin, holds complete high until the
  // cycle after the next begin (stale level seen by the first WAIT cycle).
  always @(posedge clk) begin
    begin_d <= sha_begin;
    if (begin_d) sha_complete <= 1'b0;
    if (sha_begin) begin
      s_cnt  <= 64;
      s_busy <= 1'b1;
    end else if (s_busy && !hang) begin
      if (s_cnt == 1) begin
        sha_complete <= 1'b1;
        sha_hash     <= stub_f(sha_msg);
        s_busy       <= 1'b0;
      end
      s_cnt <= s_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] ins(input logic [511:0] t, input logic [31:0] n);
    logic [511:0] r;
    r = t;
    r[511-32*NW -: 32] = n;
    return r;
  endfunction

  function automatic exp_t mk(bit f, bit x, bit t, bit a, logic [31:0] fn, logic [255:0] fh,
                              logic [31:0] hd, int nb, int ci, int en);
    exp_t e;
    e.found = f; e.exhausted = x; e.tmo = t; e.aborted = a;
    e.fnonce = fn; e.fhash = fh; e.done_cnt = hd; e.begins = nb;
    e.cmp_to_idle = ci; e.en_cycles = en;
    return e;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_flags"}, {found, exhausted, timeout, aborted}, 0);
    chk({tag, "_fnonce"}, found_nonce, 0);
    chk({tag, "_fhash"}, found_hash, 0);
    chk({tag, "_hdone"}, hashes_done, 0);
    chk({tag, "_msg"}, sha_msg, 0);
    chk({tag, "_strobes"}, {sha_begin, sha_enable}, 0);
  endtask

  // Drive one sweep, monitor it to completion, then compare with the scoreboard.
  task automatic sweep(input string tag, input logic [31:0] ns, input logic [31:0] ne,
                       input logic [255:0] tgt, input int stop_at, input bit stop_with_start,
                       input exp_t e);
    logic [511:0] tmpl;
    logic [31:0]  n;
    exp_t         x;
    int           begins, en, since;
    bit           last_en, prev_cmp, ended;
    for (int w = 0; w < 16; w++) tmpl[32*w +: 32] = $urandom;
    sb.push_back(e);
    @(negedge clk);
    msg_template = tmpl; target = tgt; nonce_start = ns; nonce_end = ne;
    start = 1'b1; stop = stop_with_start;
    n = ns; begins = 0; en = 0; since = -1; last_en = 1'b0; ended = 1'b0;
    prev_cmp = sha_complete;
    for (int i = 0; i < 20000 && !ended; i++) begin
      @(negedge clk);
      start = 1'b0;
      stop  = (i == stop_at);
      if (sha_complete && !prev_cmp) since = 0;
      else if (since >= 0) since++;
      prev_cmp = sha_complete;
      if (busy) begin
        if (sha_begin) begin
          chk({tag, "_msg"}, sha_msg, ins(tmpl, n));
          n++;
          begins++;
        end
        if (sha_enable) en++;
        last_en = sha_enable;
      end else begin
        ended = 1'b1;
      end
    end
    stop = 1'b0;
    if (!ended) chk({tag, "_end_wait"}, 0, 1);
    x = sb.pop_front();
    chk({tag, "_flags"}, {found, exhausted, timeout, aborted}, {x.found, x.exhausted, x.tmo, x.aborted});
    chk({tag, "_hdone"}, hashes_done, x.done_cnt);
    chk({tag, "_begins"}, begins, x.begins);
    chk({tag, "_en_done"}, last_en, 0);
    if (x.found) begin
      chk({tag, "_fnonce"}, found_nonce, x.fnonce);
      chk({tag, "_fhash"}, found_hash, x.fhash);
    end
    if (x.cmp_to_idle >= 0) chk({tag, "_lat"}, since, x.cmp_to_idle);
    if (x.en_cycles >= 0) chk({tag, "_en_cyc"}, en, x.en_cycles);
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; stop = 1'b0;
    msg_template = '0; target = '0; nonce_start = '0; nonce_end = '0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    n_rst = 1'b1;

    // 1: every digest beats all-ones -> first nonce hits, busy drops 3 cycles after complete.
    sweep("t1", 32'd5, 32'd9, {256{1'b1}}, -1, 1'b0,
          mk(1, 0, 0, 0, 32'd5, {32'd5, {224{1'b1}}}, 32'd1, 1, 3, -1));

    // 2: zero target never hits -> whole range checked.
    sweep("t2", 32'd0, 32'd3, 256'd0, -1, 1'b0,
          mk(0, 1, 0, 0, '0, '0, 32'd4, 4, -1, -1));

    // 3: range wraps through zero, only nonce 0 hits.
    hit_en = 1'b1; hit_nonce = 32'h0000_0000;
    sweep("t3", 32'hFFFF_FFFE, 32'h0000_0001, 256'h100, -1, 1'b0,
          mk(1, 0, 0, 0, 32'h0, 256'd0, 32'd3, 3, -1, -1));
    hit_en = 1'b0;

    // 4: core never completes -> timeout after 127 WAIT cycles (+1 LOAD with enable).
    hang = 1'b1;
    sweep("t4", 32'd7, 32'd8, 256'd0, -1, 1'b0,
          mk(0, 0, 1, 0, '0, '0, 32'd0, 1, -1, 128));
    hang = 1'b0;

    // 5: stop mid-WAIT of the first nonce -> aborted after that hash.
    sweep("t5a", 32'd10, 32'd100, 256'h100, 20, 1'b0,
          mk(0, 0, 0, 1, '0, '0, 32'd1, 1, -1, -1));
    // 5b: same stop but the nonce hits -> found takes priority.
    hit_en = 1'b1; hit_nonce = 32'd10;
    sweep("t5b", 32'd10, 32'd100, 256'h100, 20, 1'b0,
          mk(1, 0, 0, 0, 32'd10, 256'd10, 32'd1, 1, -1, -1));
    hit_en = 1'b0;
    // 5c: stop with start in IDLE is ignored -> range runs to exhaustion.
    sweep("t5c", 32'd0, 32'd1, 256'd0, -1, 1'b1,
          mk(0, 1, 0, 0, '0, '0, 32'd2, 2, -1, -1));

    // 6: stale complete level at start is ignored; reset mid-WAIT zeroes outputs.
    @(negedge clk);
    chk("t6_stale_lvl", sha_complete, 1);
    msg_template = {16{32'h1234_5678}}; target = 256'd0;
    nonce_start = 32'd0; nonce_end = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("t6_busy", busy, 1);
    chk("t6_hdone", hashes_done, 0);
    n_rst = 1'b0;
    #1;
    chk_zero("t6_rst");
    @(negedge clk);
    n_rst = 1'b1;

    // Recovery after reset.
    sweep("t7", 32'd20, 32'd21, {256{1'b1}}, -1, 1'b0,
          mk(1, 0, 0, 0, 32'd20, {32'd20, {224{1'b1}}}, 32'd1, 1, 3, -1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
